// File: rtl/osd_cmd_seq.sv
// OSD command sequencer: turns a command into a strobed 16-bit word burst on io_din.
// Optional feature macro: OSD_CMD_INFO_EN (info-window transfers of op 2).
module osd_cmd_seq #(
    parameter int unsigned GAP  = 1,
    parameter int unsigned HOLD = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_row,
    input  logic [11:0] info_x,
    input  logic [11:0] info_y,
    input  logic [5:0]  info_w,
    input  logic [5:0]  info_h,
    input  logic [1:0]  info_rot,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    input  logic        abort,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEL  = 3'd1;
    localparam logic [2:0] ST_STRB = 3'd2;
    localparam logic [2:0] ST_GAPW = 3'd3;
    localparam logic [2:0] ST_END  = 3'd4;

    localparam logic [1:0] OP_DIS   = 2'd0;
    localparam logic [1:0] OP_EN    = 2'd1;
    localparam logic [1:0] OP_INFO  = 2'd2;
    localparam logic [1:0] OP_WRITE = 2'd3;

    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);
    localparam logic [2:0] HOLD_LAST = 3'(HOLD - 1);

    function automatic logic [15:0] cmd_word_f(input logic [1:0] op, input logic [4:0] row);
        logic [15:0] w;
        case (op)
            OP_DIS:   w = 16'h0040;
            OP_EN:    w = 16'h0041;
            OP_INFO:  w = 16'h0045;
            OP_WRITE: w = {8'h00, 8'h20 | {3'b000, row}};
            default:  w = 16'h0000;
        endcase
        return w;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic [2:0]  hold_q, hold_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  row_q, row_d;
    logic        errf_q, errf_d;
    logic        cmd_ready_q, osd_q, strobe_q, busy_q, done_q, err_q;
    logic [15:0] din_q, din_d;
    logic [15:0] word_s;
    logic        accept_s, last_s, gap_done_s, wr_take_s, done_d;

    assign accept_s   = cmd_valid && cmd_ready_q;
    assign gap_done_s = (gap_q >= GAP_LAST);

`ifdef OSD_CMD_INFO_EN
    logic [11:0] info_x_q, info_y_q;
    logic [5:0]  info_w_q, info_h_q;
    logic [1:0]  info_rot_q;

    // Info window fields are captured once, at command accept.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            info_x_q   <= 12'h000;
            info_y_q   <= 12'h000;
            info_w_q   <= 6'h00;
            info_h_q   <= 6'h00;
            info_rot_q <= 2'b00;
        end else if (accept_s && (state_q == ST_IDLE)) begin
            info_x_q   <= info_x;
            info_y_q   <= info_y;
            info_w_q   <= info_w;
            info_h_q   <= info_h;
            info_rot_q <= info_rot;
        end else begin
            info_x_q   <= info_x_q;
            info_y_q   <= info_y_q;
            info_w_q   <= info_w_q;
            info_h_q   <= info_h_q;
            info_rot_q <= info_rot_q;
        end
    end
`else
    logic unused_info_s;
    assign unused_info_s = ^{info_x, info_y, info_w, info_h, info_rot};
`endif

    // Last-word detection on the 9-bit word index (index of the word currently on io_din).
    always_comb begin
        case (op_q)
            OP_WRITE: last_s = (cnt_q == 9'd256);
`ifdef OSD_CMD_INFO_EN
            OP_INFO:  last_s = (cnt_q == 9'd5);
`endif
            default:  last_s = (cnt_q == 9'd0);
        endcase
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        hold_d    = hold_q;
        op_d      = op_q;
        row_d     = row_q;
        errf_d    = errf_q;
        wr_take_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d   = cmd_op;
                    row_d  = cmd_row;
                    hold_d = 3'd0;
`ifdef OSD_CMD_INFO_EN
                    errf_d  = 1'b0;
                    state_d = ST_SEL;
`else
                    // Info transfers are rejected outright: straight to the final END cycle.
                    if (cmd_op == OP_INFO) begin
                        errf_d  = 1'b1;
                        hold_d  = HOLD_LAST;
                        state_d = ST_END;
                    end else begin
                        errf_d  = 1'b0;
                        state_d = ST_SEL;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEL: begin
                if (abort) begin
                    errf_d  = 1'b1;
                    hold_d  = 3'd0;
                    state_d = ST_END;
                end else begin
                    cnt_d   = 9'd0;
                    state_d = ST_STRB;
                end
            end
            ST_STRB: begin
                if (abort) begin
                    errf_d  = 1'b1;
                    hold_d  = 3'd0;
                    state_d = ST_END;
                end else begin
                    gap_d   = 4'd0;
                    state_d = ST_GAPW;
                end
            end
            ST_GAPW: begin
                if (abort) begin
                    errf_d  = 1'b1;
                    hold_d  = 3'd0;
                    state_d = ST_END;
                end else if (!gap_done_s) begin
                    gap_d = gap_q + 4'd1;
                end else if (last_s) begin
                    hold_d  = 3'd0;
                    state_d = ST_END;
                end else if ((op_q == OP_WRITE) && !wr_valid) begin
                    state_d = ST_GAPW;
                end else begin
                    wr_take_s = (op_q == OP_WRITE);
                    cnt_d     = cnt_q + 9'd1;
                    state_d   = ST_STRB;
                end
            end
            ST_END: begin
                if (hold_q >= HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word selected for the next strobe, indexed by the next word count.
    always_comb begin
        if (cnt_d == 9'd0) begin
            word_s = cmd_word_f(op_q, row_q);
        end else if (op_q == OP_WRITE) begin
            word_s = {8'h00, wr_data};
        end else begin
`ifdef OSD_CMD_INFO_EN
            case (cnt_d[2:0])
                3'd1:    word_s = {4'h0, info_x_q};
                3'd2:    word_s = {4'h0, info_y_q};
                3'd3:    word_s = {10'h000, info_w_q};
                3'd4:    word_s = {10'h000, info_h_q};
                3'd5:    word_s = {14'h0000, info_rot_q};
                default: word_s = 16'h0000;
            endcase
`else
            word_s = 16'h0000;
`endif
        end
    end

    // Output word is loaded on entry to STRB and held through the gap.
    always_comb begin
        if ((state_d == ST_STRB) && (state_q != ST_STRB)) begin
            din_d = word_s;
        end else begin
            din_d = din_q;
        end
        done_d = (state_d == ST_END) && (hold_d >= HOLD_LAST);
    end

    // State, counters and latched command fields.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 9'd0;
            gap_q   <= 4'd0;
            hold_q  <= 3'd0;
            op_q    <= 2'd0;
            row_q   <= 5'd0;
            errf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            op_q    <= op_d;
            row_q   <= row_d;
            errf_q  <= errf_d;
        end
    end

    // Registered outputs decoded from the next state so they line up with it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_q <= 1'b0;
            osd_q       <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            din_q       <= 16'h0000;
        end else begin
            cmd_ready_q <= (state_d == ST_IDLE);
            osd_q       <= (state_d == ST_SEL) || (state_d == ST_STRB) || (state_d == ST_GAPW);
            strobe_q    <= (state_d == ST_STRB);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
            err_q       <= done_d && errf_d;
            din_q       <= din_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign io_osd    = osd_q;
    assign io_strobe = strobe_q;
    assign io_din    = din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    // Handshake ack must coincide with the consuming edge, so it stays combinational.
    assign wr_ready  = wr_take_s;

endmodule

// File: tb/tb_osd_cmd_seq.sv
// Directed self-checking bench for osd_cmd_seq (GAP=1, HOLD=2).
module tb_osd_cmd_seq;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_row;
    logic [11:0] info_x, info_y;
    logic [5:0]  info_w, info_h;
    logic [1:0]  info_rot;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_data;
    logic        abort;
    logic        io_osd, io_strobe;
    logic [15:0] io_din;
    logic        busy, done, err;

    int n_vec = 0;
    int n_err = 0;

    int n_strb, osd_cnt, first_strb, last_osd, done_cyc, done_cnt, abort_cyc;
    int bad_data, bad_gap, prev_strb;
    logic        err_at_done;
    logic [15:0] words[$];

    osd_cmd_seq #(.GAP(1), .HOLD(2)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .info_x    (info_x),
        .info_y    (info_y),
        .info_w    (info_w),
        .info_h    (info_h),
        .info_rot  (info_rot),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .abort     (abort),
        .io_osd    (io_osd),
        .io_strobe (io_strobe),
        .io_din    (io_din),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one accept edge, then scramble the inputs.
    task automatic issue(input logic [1:0] op, input logic [4:0] row);
        @(negedge clk_sys);
        check_val("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_row   = row;
        info_x    = 12'd100;
        info_y    = 12'd50;
        info_w    = 6'd8;
        info_h    = 6'd4;
        info_rot  = 2'd1;
        cmd_valid = 1'b1;
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_row   = ~row;
        info_x    = 12'hfff;
        info_y    = 12'hfff;
        info_w    = 6'h3f;
        info_h    = 6'h3f;
        info_rot  = 2'd3;
    endtask

    // Observe one transfer cycle by cycle (cycle 1 = first cycle after accept).
    task automatic run_xfer(input bit is_wr, input int abort_at, input int rst_at, input int max_c);
        bit fin;
        bit ab_prev;
        int stall_left;
        int nb;
        words.delete();
        n_strb = 0; osd_cnt = 0; first_strb = -1; last_osd = -1; done_cyc = -1;
        done_cnt = 0; abort_cyc = -1; bad_gap = 0; prev_strb = -1; err_at_done = 1'b0;
        stall_left = 10; ab_prev = 1'b0; fin = 1'b0;
        for (int c = 1; c <= max_c && !fin; c++) begin
            @(negedge clk_sys);
            if (ab_prev) begin
                check_val("abort_osd_low", 32'(io_osd), 32'd0);
                check_val("abort_strobe_low", 32'(io_strobe), 32'd0);
            end
            ab_prev = 1'b0;
            abort   = 1'b0;
            if (io_osd) begin
                osd_cnt++;
                last_osd = c;
            end
            if (io_strobe) begin
                words.push_back(io_din);
                n_strb++;
                if (first_strb < 0) first_strb = c;
                if (prev_strb >= 0 && (c - prev_strb) != 2 && !is_wr) bad_gap++;
                prev_strb = c;
            end
            if (done) begin
                done_cnt++;
                done_cyc    = c;
                err_at_done = err;
            end
            if (done_cyc > 0 && c == done_cyc + 1) begin
                check_val("ready_after_done", 32'(cmd_ready), 32'd1);
                fin = 1'b1;
            end
            if (abort_at >= 0 && io_strobe && (n_strb - 1) == abort_at) begin
                abort     = 1'b1;
                ab_prev   = 1'b1;
                abort_cyc = c;
            end
            if (rst_at >= 0 && io_strobe && n_strb == rst_at) begin
                reset_n = 1'b0;
                #1;
                check_val("rst_async_zero",
                          32'({cmd_ready, io_osd, io_strobe, wr_ready, busy, done, err, io_din}), 32'd0);
                repeat (2) begin
                    @(negedge clk_sys);
                    if (done) done_cnt++;
                end
                reset_n = 1'b1;
                fin     = 1'b1;
            end
            if (is_wr) begin
                nb      = (n_strb >= 1) ? n_strb - 1 : 0;
                wr_data = nb[7:0];
                if (nb == 128 && !io_strobe && stall_left > 0) begin
                    wr_valid = 1'b0;
                    stall_left--;
                end else begin
                    wr_valid = (nb < 256);
                end
            end
        end
        check_val("xfer_finished", 32'(fin), 32'd1);
        wr_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic check_write_bytes();
        bad_data = 0;
        for (int k = 1; k < n_strb; k++) begin
            if (words[k] !== {8'h00, 8'(k - 1)}) bad_data++;
        end
        check_val("wr_bytes_in_order", 32'(bad_data), 32'd0);
    endtask

    task automatic check_enable();
        check_val("en_strobes", 32'(n_strb), 32'd1);
        check_val("en_word", 32'(words[0]), 32'h0041);
        check_val("en_osd_cycles", 32'(osd_cnt), 32'd3);
        check_val("en_latency", 32'(first_strb), 32'd2);
        check_val("en_done_after_osd", 32'(done_cyc), 32'(last_osd + 2));
        check_val("en_err", 32'(err_at_done), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_row = 5'd0;
        info_x = 12'd0; info_y = 12'd0; info_w = 6'd0; info_h = 6'd0; info_rot = 2'd0;
        wr_valid = 1'b0; wr_data = 8'd0; abort = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_sys);
        check_val("rst_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_outputs", 32'({io_osd, io_strobe, wr_ready, busy, done, err, io_din}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check_val("ready_after_release", 32'(cmd_ready), 32'd1);
        check_val("idle_not_busy", 32'(busy), 32'd0);

        // Enable command
        issue(2'd1, 5'd0);
        run_xfer(1'b0, -1, -1, 50);
        check_enable();

        // Disable command
        issue(2'd0, 5'd0);
        run_xfer(1'b0, -1, -1, 50);
        check_val("dis_word", 32'(words[0]), 32'h0040);
        check_val("dis_strobes", 32'(n_strb), 32'd1);

        // Info window
        issue(2'd2, 5'd0);
        run_xfer(1'b0, -1, -1, 60);
`ifdef OSD_CMD_INFO_EN
        check_val("info_strobes", 32'(n_strb), 32'd6);
        check_val("info_w0", 32'(words[0]), 32'h0045);
        check_val("info_w1", 32'(words[1]), 32'd100);
        check_val("info_w2", 32'(words[2]), 32'd50);
        check_val("info_w3", 32'(words[3]), 32'd8);
        check_val("info_w4", 32'(words[4]), 32'd4);
        check_val("info_w5", 32'(words[5]), 32'd1);
        check_val("info_spacing", 32'(bad_gap), 32'd0);
        check_val("info_err", 32'(err_at_done), 32'd0);
`else
        check_val("info_off_osd", 32'(osd_cnt), 32'd0);
        check_val("info_off_strobes", 32'(n_strb), 32'd0);
        check_val("info_off_done_cyc", 32'(done_cyc), 32'd1);
        check_val("info_off_err", 32'(err_at_done), 32'd1);
`endif

        // Write row 9, 256-byte ramp, 10-cycle stall at byte 128
        issue(2'd3, 5'd9);
        run_xfer(1'b1, -1, -1, 1000);
        check_val("wr_strobes", 32'(n_strb), 32'd257);
        check_val("wr_first_word", 32'(words[0]), 32'h0029);
        check_write_bytes();
        check_val("wr_osd_cycles", 32'(osd_cnt), 32'd525);
        check_val("wr_latency", 32'(first_strb), 32'd2);
        check_val("wr_done_after_osd", 32'(done_cyc), 32'(last_osd + 2));
        check_val("wr_err", 32'(err_at_done), 32'd0);

        // Abort during write byte 40, then a normal enable
        issue(2'd3, 5'd1);
        run_xfer(1'b1, 40, -1, 1000);
        check_val("ab_strobes", 32'(n_strb), 32'd41);
        check_write_bytes();
        check_val("ab_done_cyc", 32'(done_cyc), 32'(abort_cyc + 2));
        check_val("ab_err", 32'(err_at_done), 32'd1);
        check_val("ab_done_cnt", 32'(done_cnt), 32'd1);
        issue(2'd1, 5'd0);
        run_xfer(1'b0, -1, -1, 50);
        check_enable();

        // Reset pulse mid-write
        issue(2'd3, 5'd2);
        run_xfer(1'b1, -1, 61, 1000);
        check_val("rst_no_done", 32'(done_cnt), 32'd0);
        @(negedge clk_sys);
        check_val("rst_ready_after", 32'(cmd_ready), 32'd1);
        check_val("rst_osd_after", 32'(io_osd), 32'd0);
        issue(2'd1, 5'd0);
        run_xfer(1'b0, -1, -1, 50);
        check_enable();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
